// File: rtl/fft_wb_sequencer.sv
// FFT write-back sequencer: queues AGU address pairs and issues result-memory writes per butterfly.
// Optional macro FFT_WB_ADDR_CHECK_EN adds a butterfly address-pair consistency check on each pop.
//
// state | meaning
// IDLE  | waiting for c_wb_start
// RUN   | accepting address pairs and issuing writes
// DONE  | final write issued; returns to IDLE next cycle
module fft_wb_sequencer #(
    parameter int LOG_N      = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             pulse,
    input  logic             reset,
    input  logic             c_wb_start,
    input  logic             ab_valid,
    input  logic [LOG_N-1:0] ab_upper,
    input  logic [LOG_N-1:0] ab_lower,
    output logic             ab_ready,
    input  logic             res_valid,
    output logic             wr_en,
    output logic [LOG_N-1:0] wr_upper,
    output logic [LOG_N-1:0] wr_lower,
    output logic             stage_done,
    output logic             fft_done,
    output logic             wb_err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int BW = (LOG_N > 1) ? LOG_N - 1 : 1;
    localparam int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;
    localparam logic [AW:0]   FULL       = (AW + 1)'(FIFO_DEPTH);
    localparam logic [SW-1:0] LAST_STAGE = SW'(LOG_N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [LOG_N-1:0] fifo_u [FIFO_DEPTH];
    logic [LOG_N-1:0] fifo_l [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [BW-1:0]    bfly_cnt;
    logic [SW-1:0]    stage_cnt;
    logic             in_run;
    logic             push;
    logic             pop;
    logic             underflow;
    logic             addr_bad;

    // Ready comes from the registered count, so a full FIFO refuses a push even while popping.
    assign in_run    = (state == RUN);
    assign ab_ready  = in_run && (count != FULL);
    assign push      = ab_valid && ab_ready;
    assign pop       = in_run && res_valid && (count != '0);
    assign underflow = in_run && res_valid && (count == '0);

`ifdef FFT_WB_ADDR_CHECK_EN
    logic [LOG_N-1:0] stage_bit;
    assign stage_bit = LOG_N'(1) << stage_cnt;
    assign addr_bad  = pop && (((fifo_u[rd_ptr] ^ fifo_l[rd_ptr]) != stage_bit) ||
                               ((fifo_u[rd_ptr] & stage_bit) != '0));
`else
    assign addr_bad = 1'b0;
`endif

    always_ff @(posedge pulse) begin
        if (push) begin
            fifo_u[wr_ptr] <= ab_upper;
            fifo_l[wr_ptr] <= ab_lower;
        end
    end

    always_ff @(posedge pulse) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            bfly_cnt   <= '0;
            stage_cnt  <= '0;
            wr_en      <= 1'b0;
            wr_upper   <= '0;
            wr_lower   <= '0;
            stage_done <= 1'b0;
            fft_done   <= 1'b0;
            wb_err     <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            stage_done <= 1'b0;
            fft_done   <= 1'b0;
            if (underflow || addr_bad) begin
                wb_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (c_wb_start) begin
                        state     <= RUN;
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                        count     <= '0;
                        bfly_cnt  <= '0;
                        stage_cnt <= '0;
                    end
                end
                RUN: begin
                    if (push) begin
                        wr_ptr <= wr_ptr + AW'(1);
                    end
                    if (pop) begin
                        rd_ptr   <= rd_ptr + AW'(1);
                        wr_en    <= 1'b1;
                        wr_upper <= fifo_u[rd_ptr];
                        wr_lower <= fifo_l[rd_ptr];
                        bfly_cnt <= bfly_cnt + BW'(1);
                        if (&bfly_cnt) begin
                            stage_done <= 1'b1;
                            if (stage_cnt == LAST_STAGE) begin
                                fft_done <= 1'b1;
                                state    <= DONE;
                            end else begin
                                stage_cnt <= stage_cnt + SW'(1);
                            end
                        end
                    end
                    case ({push, pop})
                        2'b10:   count <= count + (AW + 1)'(1);
                        2'b01:   count <= count - (AW + 1)'(1);
                        default: count <= count;
                    endcase
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_wb_sequencer.sv
// Self-checking bench for fft_wb_sequencer (LOG_N=3, FIFO_DEPTH=4): vector table plus write scoreboard.
module tb_fft_wb_sequencer;
    localparam int LOG_N      = 3;
    localparam int FIFO_DEPTH = 4;
`ifdef FFT_WB_ADDR_CHECK_EN
    localparam logic ADDR_ERR = 1'b1;
`else
    localparam logic ADDR_ERR = 1'b0;
`endif

    typedef struct {
        logic       start;
        logic       av;
        logic [5:0] pair;
        logic       rv;
        logic       exp_ready;
        logic       exp_wr;
        logic       exp_sd;
        logic       exp_fd;
        logic       exp_err;
    } vec_t;

    logic       pulse = 1'b0;
    logic       reset = 1'b0;
    logic       c_wb_start = 1'b0;
    logic       ab_valid = 1'b0;
    logic       res_valid = 1'b0;
    logic [2:0] ab_upper = '0;
    logic [2:0] ab_lower = '0;
    logic       ab_ready;
    logic       wr_en;
    logic [2:0] wr_upper;
    logic [2:0] wr_lower;
    logic       stage_done;
    logic       fft_done;
    logic       wb_err;

    int         n_chk = 0;
    int         n_err = 0;
    logic [5:0] sb_q[$];
    logic [5:0] last_pair = '0;

    always #5 pulse = ~pulse;

    fft_wb_sequencer #(.LOG_N(LOG_N), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .pulse(pulse), .reset(reset), .c_wb_start(c_wb_start),
        .ab_valid(ab_valid), .ab_upper(ab_upper), .ab_lower(ab_lower), .ab_ready(ab_ready),
        .res_valid(res_valid), .wr_en(wr_en), .wr_upper(wr_upper), .wr_lower(wr_lower),
        .stage_done(stage_done), .fft_done(fft_done), .wb_err(wb_err)
    );

    function automatic vec_t mk(logic st, logic av, logic [5:0] pr, logic rv,
                                logic rdy, logic wr, logic sd, logic fd, logic er);
        vec_t v;
        v.start = st; v.av = av; v.pair = pr; v.rv = rv;
        v.exp_ready = rdy; v.exp_wr = wr; v.exp_sd = sd; v.exp_fd = fd; v.exp_err = er;
        return v;
    endfunction

    // Legal butterfly pair for global index idx (4 butterflies per stage).
    function automatic logic [5:0] pair_of(int idx);
        int s  = idx / 4;
        int b  = idx % 4;
        int lo = b & ((1 << s) - 1);
        int hi = (b >> s) << (s + 1);
        int u  = hi | lo;
        int l  = u | (1 << s);
        logic [2:0] uu = 3'(u);
        logic [2:0] ll = 3'(l);
        return {uu, ll};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [5:0] exp_p;
        c_wb_start = v.start;
        ab_valid   = v.av;
        ab_upper   = v.pair[5:3];
        ab_lower   = v.pair[2:0];
        res_valid  = v.rv;
        #1;
        chk({tag, " ab_ready"}, 32'(ab_ready), 32'(v.exp_ready));
        if (v.av && v.exp_ready) sb_q.push_back(v.pair);
        @(posedge pulse);
        #1;
        chk({tag, " wr_en"}, 32'(wr_en), 32'(v.exp_wr));
        chk({tag, " stage_done"}, 32'(stage_done), 32'(v.exp_sd));
        chk({tag, " fft_done"}, 32'(fft_done), 32'(v.exp_fd));
        chk({tag, " wb_err"}, 32'(wb_err), 32'(v.exp_err));
        if (v.exp_wr) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL %s scoreboard: write expected but no pair queued", tag);
            end else begin
                exp_p = sb_q.pop_front();
                last_pair = exp_p;
            end
        end
        chk({tag, " wr_addr"}, 32'({wr_upper, wr_lower}), 32'(last_pair));
        @(negedge pulse);
    endtask

    // Reset with all other inputs active to show reset priority.
    task automatic do_reset(input string tag);
        reset = 1'b0; c_wb_start = 1'b1; ab_valid = 1'b1; res_valid = 1'b1;
        ab_upper = 3'd5; ab_lower = 3'd4;
        @(posedge pulse);
        #1;
        chk({tag, " rst wr_en"}, 32'(wr_en), 0);
        chk({tag, " rst wr_addr"}, 32'({wr_upper, wr_lower}), 0);
        chk({tag, " rst stage_done"}, 32'(stage_done), 0);
        chk({tag, " rst fft_done"}, 32'(fft_done), 0);
        chk({tag, " rst wb_err"}, 32'(wb_err), 0);
        chk({tag, " rst ab_ready"}, 32'(ab_ready), 0);
        @(negedge pulse);
        reset = 1'b1; c_wb_start = 1'b0; ab_valid = 1'b0; res_valid = 1'b0;
        sb_q.delete();
        last_pair = '0;
    endtask

    // Push pair i in cycle i, res_valid two cycles later; nwr writes observed.
    task automatic run_pass(input int npush, input int nwr, input logic er, input string tag);
        for (int i = 0; i <= nwr + 1; i++) begin
            int k = i - 1;
            apply(mk(1'b0, i < npush, pair_of(i), i >= 2, 1'b1, i >= 2,
                     (i >= 2) && (k % 4 == 0), k == 12, er), tag);
        end
    endtask

    initial begin
        vec_t tbl[$];
        tbl.push_back(mk(1, 0, 6'o00, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 6'o01, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 6'o23, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 6'o45, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 6'o67, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 6'o10, 1, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 6'o00, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 6'o00, 1, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 6'o00, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, pair_of(4), 1, 1, 0, 0, 0, 1));

        do_reset("init");

        apply(mk(1, 0, 6'o00, 0, 0, 0, 0, 0, 0), "start1");
        run_pass(12, 12, 1'b0, "full");
        apply(mk(0, 0, 6'o00, 0, 0, 0, 0, 0, 0), "done1");

        for (int t = 0; t < tbl.size(); t++) begin
            apply(tbl[t], $sformatf("tbl%0d", t));
        end
        // One pair stays queued after the underflow; pop it while streaming the rest.
        for (int j = 5; j <= 12; j++) begin
            apply(mk(0, j <= 11, pair_of(j), 1, 1, 1, j % 4 == 0, j == 12, 1), "stream");
        end
        apply(mk(1, 1, 6'o01, 1, 0, 0, 0, 0, 1), "done_ign");
        apply(mk(0, 1, 6'o01, 1, 0, 0, 0, 0, 1), "idle_ign");
        apply(mk(1, 0, 6'o00, 0, 0, 0, 0, 0, 1), "start_err");
        run_pass(7, 5, 1'b1, "partial");

        do_reset("mid");
        apply(mk(0, 0, 6'o00, 1, 0, 0, 0, 0, 0), "post_rst");
        apply(mk(1, 0, 6'o00, 0, 0, 0, 0, 0, 0), "start2");
        run_pass(12, 12, 1'b0, "clean");
        apply(mk(0, 0, 6'o00, 0, 0, 0, 0, 0, 0), "done2");

        apply(mk(1, 0, 6'o00, 0, 0, 0, 0, 0, 0), "start3");
        apply(mk(0, 1, {3'd2, 3'd3}, 0, 1, 0, 0, 0, 0), "ac_push1");
        apply(mk(0, 1, {3'd4, 3'd6}, 0, 1, 0, 0, 0, 0), "ac_push2");
        apply(mk(0, 0, 6'o00, 1, 1, 1, 0, 0, 0), "ac_pop1");
        apply(mk(0, 0, 6'o00, 1, 1, 1, 0, 0, ADDR_ERR), "ac_pop2");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/fft_wb_sequencer.md
FFT_WB_SEQUENCER -- requirements
Module: fft_wb_sequencer

Interface
REQ-001 Parameter LOG_N, default 6, log2 of FFT point count N; N/2 butterflies per stage, LOG_N stages.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two >= 2, address-pair entries held between the AGU and the butterfly result.
REQ-003 pulse  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 c_wb_start  input  1  starts one write-back pass when high in IDLE.
REQ-006 ab_valid  input  1  an AGU address pair is presented.
REQ-007 ab_upper  input  LOG_N  upper butterfly address from the AGU.
REQ-008 ab_lower  input  LOG_N  lower butterfly address from the AGU.
REQ-009 ab_ready  output  1  the pair is accepted this cycle; combinational, high only in RUN with FIFO not full.
REQ-010 res_valid  input  1  butterfly datapath presents one result pair.
REQ-011 wr_en  output  1  registered write strobe for the result memory.
REQ-012 wr_upper  output  LOG_N  registered write address for the upper result.
REQ-013 wr_lower  output  LOG_N  registered write address for the lower result.
REQ-014 stage_done  output  1  one-cycle pulse after the last write of a stage.
REQ-015 fft_done  output  1  one-cycle pulse after the last write of the final stage.
REQ-016 wb_err  output  1  sticky error flag.

Function
REQ-017 The FSM has states IDLE, RUN and DONE; IDLE->RUN when c_wb_start=1, RUN->DONE on the cycle the final write issues, DONE->IDLE unconditionally after one cycle.
REQ-018 A push occurs when ab_valid & ab_ready; the pair is stored in FIFO order.
REQ-019 In RUN, a pop occurs when res_valid=1 and the FIFO is non-empty; the next cycle shows wr_en=1 and the popped pair on wr_upper/wr_lower (latency 1).
REQ-020 wr_en is 0 in every cycle not following a pop; wr_upper/wr_lower hold their last value when wr_en=0.
REQ-021 Simultaneous push and pop are both performed; a full FIFO accepts no push even when a pop occurs that cycle (ab_ready is computed from the registered count).
REQ-022 There is no bypass: res_valid in RUN with an empty FIFO is an underflow, sets wb_err, and produces no write, even if a push occurs in the same cycle.
REQ-023 A butterfly counter of LOG_N-1 bits increments per write and wraps from N/2-1 to 0; on the wrap, stage_done pulses in the cycle wr_en is high for that last write and the stage counter increments.
REQ-024 When the stage counter reaches LOG_N-1 and the butterfly counter wraps, stage_done and fft_done pulse together and the FSM enters DONE.
REQ-025 In IDLE and DONE, ab_ready=0, res_valid is ignored without an error, and c_wb_start in DONE is ignored.
REQ-026 Entering RUN clears the butterfly counter, stage counter and FIFO; wb_err is not cleared.

Reset
REQ-027 On reset=0 at a rising edge: state IDLE, FIFO empty, counters 0, wr_en=0, wr_upper=0, wr_lower=0, stage_done=0, fft_done=0, wb_err=0.
REQ-028 Reset mid-pass aborts immediately with no further writes and no done pulses; reset has priority over every other input.

Configuration
REQ-029 With macro FFT_WB_ADDR_CHECK_EN defined, each pop checks that ab_upper XOR ab_lower of the popped pair equals 1<<stage and that the pair's upper bit at the stage position is 0; a mismatch sets wb_err, and the write still issues.
REQ-030 Without FFT_WB_ADDR_CHECK_EN, no address check logic exists and wb_err is set only by underflow.

Verification
REQ-031 LOG_N=3, start, push 12 valid pairs, with one res_valid per push two cycles later -> 12 writes in order, stage_done on writes 4, 8 and 12, fft_done with write 12, then IDLE.
REQ-032 FIFO_DEPTH=4, push 4 pairs with no res_valid -> ab_ready=0 after the 4th push; one pop plus ab_valid in the same cycle -> pop only, and ab_ready=1 on the next cycle.
REQ-033 RUN with an empty FIFO, res_valid=1 -> wr_en stays 0 and wb_err=1 and remains 1 through a later start.
REQ-034 With FFT_WB_ADDR_CHECK_EN and stage 0, push pair (2,3) then (4,6) and pop both -> first write with no error, second write issues and wb_err=1.
REQ-035 reset=0 after the 5th write of a pass -> the next cycle shows all outputs at their reset values; a new start gives a full clean pass with no done pulse left over.
